// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_skid
// Valid/ready pipeline register: optional 2-entry skid, flush, hold, bubble mask
// Rev    : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       SKID        = 1,
  parameter logic [WIDTH-1:0]  BUBBLE_MASK = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       occupancy,
  output logic [7:0]       flush_drops
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [7:0]       drops_q, drops_d;
  logic [8:0]       drops_sum;
  logic             emit;
  logic             accept;

  assign occupancy   = state_q;
  assign flush_drops = drops_q;
  assign out_valid   = !hold && (state_q != ST_EMPTY);
  assign out_data    = out_valid ? m_q : (m_q & ~BUBBLE_MASK);
  assign emit        = out_valid && out_ready;
  assign accept      = in_valid && in_ready;

  // The skid build keeps in_ready purely registered; the single-entry build
  // lets a draining downstream refill the register in the same cycle.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = !hold && (state_q != ST_TWO);
    end else begin : g_single
      assign in_ready = !hold && ((state_q == ST_EMPTY) || out_ready);
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    s_d       = s_q;
    drops_d   = drops_q;
    drops_sum = {1'b0, drops_q} + {7'b0, occupancy};

    if (flush) begin
      // Payload registers keep stale data; the bubble mask hides it.
      state_d = ST_EMPTY;
      drops_d = drops_sum[8] ? 8'hFF : drops_sum[7:0];
    end else if (!hold) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            m_d     = in_data;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            m_d = in_data;
          end else if (accept) begin
            state_d = ST_TWO;
            s_d     = in_data;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            state_d = ST_ONE;
            m_d     = s_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      drops_q <= drops_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// Bench for pipe_stage_skid: SKID=1 and SKID=0 instances share one stimulus
// stream and are compared every cycle against a queue-level model.
module tb_pipe_stage_skid;

  localparam int W = 32;
  localparam logic [W-1:0] MASK = 32'h0000_000F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, flush, hold;
  logic [W-1:0] in_data;
  logic [1:0]   ir, ov;
  logic [W-1:0] od  [2];
  logic [1:0]   occ [2];
  logic [7:0]   fd  [2];

  pipe_stage_skid #(.WIDTH(W), .SKID(1), .BUBBLE_MASK(MASK)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .flush(flush),
    .hold(hold), .occupancy(occ[0]), .flush_drops(fd[0]));

  pipe_stage_skid #(.WIDTH(W), .SKID(0), .BUBBLE_MASK(MASK)) u_single (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .flush(flush),
    .hold(hold), .occupancy(occ[1]), .flush_drops(fd[1]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an ordered list of held entries (index 0 = oldest), the last value
  // that sat at the head (what a masked bubble still reveals), and a drop count.
  logic [W-1:0] ment  [2][2];
  logic [W-1:0] mhead [2];
  int           mcnt  [2];
  int           mdrops[2];
  bit           started = 1'b0;
  bit           m_acc, m_em;

  function automatic bit exp_ready(int k);
    if (hold) return 1'b0;
    if (k == 0) return mcnt[k] < 2;
    return (mcnt[k] == 0) || out_ready;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mcnt[k] = 0; mhead[k] = '0; mdrops[k] = 0;
      end else if (started) begin
        if (flush) begin
          mdrops[k] = (mdrops[k] + mcnt[k] > 255) ? 255 : mdrops[k] + mcnt[k];
          mcnt[k]   = 0;
        end else if (!hold) begin
          m_em  = (mcnt[k] > 0) && out_ready;
          m_acc = in_valid && exp_ready(k);
          if (m_em) begin
            ment[k][0] = ment[k][1];
            mcnt[k]--;
          end
          if (m_acc) begin
            ment[k][mcnt[k]] = in_data;
            mcnt[k]++;
          end
          if (mcnt[k] > 0) mhead[k] = ment[k][0];
        end
      end
    end
    if (rst) started = 1'b1;
  end

  bit           logging = 1'b0;
  logic [W-1:0] lg [2][32];
  int           ln [2];

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("out_valid[%0d]", k), ov[k], !hold && mcnt[k] > 0);
        check($sformatf("in_ready[%0d]", k), ir[k], exp_ready(k));
        check($sformatf("out_data[%0d]", k), od[k],
              (!hold && mcnt[k] > 0) ? mhead[k] : (mhead[k] & ~MASK));
        check($sformatf("occupancy[%0d]", k), occ[k], mcnt[k]);
        check($sformatf("flush_drops[%0d]", k), fd[k], mdrops[k]);
        if (logging && ov[k] && out_ready && ln[k] < 32) begin
          lg[k][ln[k]] = od[k];
          ln[k]++;
        end
      end
      check("single_occ_le1", occ[1] <= 2'd1, 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit accepted;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; hold = 1'b0;
    ln[0] = 0; ln[1] = 0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", ov[k], 0);
      check("rst_out_data", od[k], 0);
      check("rst_occ", occ[k], 0);
      check("rst_drops", fd[k], 0);
      check("rst_in_ready", ir[k], 1);
    end

    // Reset in the middle of a stream with the skid stage full.
    step();
    in_valid = 1'b1; in_data = 32'hA1; step();
    in_data = 32'hA2; step();
    in_valid = 1'b0;
    @(negedge clk);
    check("fill_occ", occ[0], 2);
    check("fill_head", od[0], 32'hA1);
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    check("midrst_occ", occ[0], 0);
    check("midrst_valid", ov[0], 0);
    check("midrst_data", od[0], 0);
    check("midrst_drops", fd[0], 0);
    check("midrst_ready", ir[0], 1);

    // Streaming with out_ready high.
    step();
    logging = 1'b1; ln[0] = 0; ln[1] = 0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 32'h10 + i; step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    logging = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("stream_count", ln[k], 16);
      for (int i = 0; i < 16; i++) check("stream_order", lg[k][i], 32'h10 + i);
    end

    // Backpressure on the skid stage.
    out_ready = 1'b0; ln[0] = 0; ln[1] = 0; logging = 1'b1;
    in_valid = 1'b1; in_data = 32'h55; step();
    in_data = 32'h66; step();
    in_data = 32'h77;
    @(negedge clk);
    check("bp_ready_full", ir[0], 0);
    check("bp_occ_full", occ[0], 2);
    step();
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 8 && !accepted; c++) begin
      @(negedge clk);
      if (ir[0]) accepted = 1'b1;
      step();
      if (accepted) in_valid = 1'b0;
    end
    check("bp_accept_77", accepted, 1);
    repeat (3) step();
    logging = 1'b0;
    check("bp_count", ln[0], 3);
    check("bp_first", lg[0][0], 32'h55);
    check("bp_second", lg[0][1], 32'h66);
    check("bp_third", lg[0][2], 32'h77);

    // Flush at occupancy 2 with an upstream transfer pending.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hB1; step();
    in_data = 32'hB2; step();
    in_data = 32'h99; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_occ", occ[0], 0);
    check("flush_drops", fd[0], 2);
    check("flush_valid", ov[0], 0);
    step();
    for (int i = 0; i < 130; i++) begin
      in_valid = 1'b1; in_data = 32'hC00 + i; step();
      step();
      flush = 1'b1; step();
      flush = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_sat", fd[0], 255);
    check("flush_sat_occ", occ[0], 0);

    // Hold with bubble masking.
    step();
    in_valid = 1'b1; in_data = 32'h1234_56AB; step();
    in_data = 32'hDEAD_BEEF; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", ov[0], 0);
      check("hold_data", od[0], 32'h1234_56A0);
      check("hold_ready", ir[0], 0);
      check("hold_occ", occ[0], 1);
      step();
    end
    hold = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("unhold_valid", ov[0], 1);
    check("unhold_data", od[0], 32'h1234_56AB);

    // Single-entry build: in_ready tracks out_ready within the cycle while full.
    check("single_full_ready_lo", ir[1], 0);
    #1 out_ready = 1'b1;
    #1 check("single_full_ready_hi", ir[1], 1);
    #1 out_ready = 1'b0;
    #1 check("single_full_ready_lo2", ir[1], 0);
    step();

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 99) < 75);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 99) < 70);
      hold      = ($urandom_range(0, 99) < 10);
      flush     = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 199) < 1);
      step();
    end
    rst = 1'b0; flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register, the generic successor to the fixed-field inter-stage latches between EX, MEM and WB. It carries an arbitrary WIDTH-bit bundle under a valid/ready handshake, with an optional 2-entry skid buffer so upstream `in_ready` is registered. It also provides explicit flush and hold controls, and forces selected control bits to zero whenever the stage presents a bubble. A saturating counter records how many live entries were discarded by flushes, for CP0/exception debug.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits; must be ≥ 1.
- `SKID`, 1: 1 = 2-entry skid (registered `in_ready`); 0 = single entry (`in_ready` combinationally depends on `out_ready`).
- `BUBBLE_MASK`, {WIDTH{1'b0}}: bits of `out_data` forced to 0 while `out_valid` = 0 (regWr, memwr, cp0op, etc.).

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  entry presented downstream.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  head payload, bubble-masked.
- `flush`  in  1  discard all held entries at this edge.
- `hold`  in  1  freeze the stage (no accept, no emit).
- `occupancy`  out  2  entries held: 0, 1 or 2.
- `flush_drops`  out  8  saturating count of entries discarded by flush.

## Operation
- Storage: main register M (head) and, if SKID=1, skid register S. The state is EMPTY, ONE or TWO; `occupancy` encodes it as 0, 1, 2.
- Combinational terms: `out_valid` = !hold && state≠EMPTY. `emit` = out_valid && out_ready. `accept` = in_valid && in_ready.
- `in_ready`:
  - SKID=1: !hold && state≠TWO.
  - SKID=0: !hold && (state==EMPTY || out_ready).
- `out_data` = M & ~BUBBLE_MASK when !out_valid; otherwise M.
- Transitions under normal operation (no rst, no flush, no hold):
  - EMPTY: accept → ONE, M←in_data.
  - ONE, accept && emit → ONE, M←in_data.
  - ONE, accept && !emit → TWO, S←in_data. Only reachable with SKID=1.
  - ONE, emit && !accept → EMPTY.
  - TWO: in_ready=0. emit → ONE, M←S. No emit → stay.
- Priority at each edge: rst > flush > hold > normal.
- rst: state←EMPTY; M, S ← 0; `flush_drops` ← 0.
- flush: state←EMPTY. M and S keep their contents, but they are invisible because the output is masked. `flush_drops` += occupancy, saturating at 255. Any upstream transfer that cycle is discarded. A flush while hold is asserted still empties the stage.
- hold: state, M and S unchanged. No transfer occurs in either direction, because both ready and valid are forced low.
- Entries leave in exactly arrival order. Nothing is duplicated or dropped except by flush or rst.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `occupancy`=0, `flush_drops`=0.
- `in_ready` after reset: 1 in the same cycle, unless hold is asserted.
- Latency from an accepting edge to `out_valid` is 1 cycle with the stage empty.
- Throughput is 1 entry/cycle sustained, with `out_ready` held high.
- SKID=1: `in_ready` depends only on registered state and `hold`. There is no combinational path from `out_ready` to `in_ready`.
- SKID=0: the combinational path `out_ready`→`in_ready` is permitted.
- `hold` and `flush` act at the edge on which they are sampled high. Deasserting `hold` restores `out_valid` in the same cycle.

## Test plan
- **Reset mid-stream.** SKID=1, fill to TWO with 0xA1, 0xA2, then assert rst for 1 cycle → next cycle occupancy=0, out_valid=0, out_data=0, flush_drops=0, and in_ready=1.
- **Streaming.** Stream 0x10..0x1F with out_ready=1 → 16 outputs in order, 1 cycle after each input, and in_ready never drops.
- **Backpressure.** SKID=1, out_ready=0 while sending 0x55, 0x66, 0x77 → only 0x55 and 0x66 are accepted, and in_ready=0 at occupancy 2. Raise out_ready → outputs 0x55, 0x66, then 0x77 is accepted and emitted.
- **Flush at full occupancy.** Flush at occupancy=2 with in_valid=1 → occupancy=0, flush_drops=2, and the upstream entry is discarded. Repeat the flush 130 times at occupancy 2 → flush_drops=255 (saturated).
- **Hold with bubble masking.** BUBBLE_MASK=0x0000000F, M=0x123456AB, assert hold for 3 cycles → out_valid=0, out_data=0x123456A0, in_ready=0, state unchanged. Release hold → out_data=0x123456AB with out_valid=1.
- **SKID=0 build.** in_ready follows out_ready in the same cycle while full. Occupancy never exceeds 1, and the streaming order check still passes.
